// File: rtl/port_tx_unit.sv
// port_tx_unit: buffers 16-bit words written by the CPU output port and sends each one on a
// UART line. Each word goes out as two 8N1 frames, low byte first. The CPU is never stalled.
// A word that arrives while the FIFO is full is dropped, and the sticky overflow flag is set.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   load      write strobe, one cycle per OUT instruction
//   data      16-bit word, sampled when load=1
//   tx        registered serial line, idle high
//   busy      FIFO non-empty or transmitter active
//   full      FIFO holds DEPTH words
//   overflow  sticky; a load was dropped because the FIFO was full
//   level     current FIFO occupancy, 0..DEPTH
module port_tx_unit #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned AW           = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [15:0]   data,
    output logic          tx,
    output logic          busy,
    output logic          full,
    output logic          overflow,
    output logic [AW:0]   level
);

    localparam int unsigned   CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BaudLast  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   CountFull = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // FIFO storage and bookkeeping
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q;
    logic          push, pop;

    // Transmitter state
    state_e        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d, next_idx;
    logic          byte_sel_q, byte_sel_d;
    logic [15:0]   word_q;
    logic          tx_q, tx_d;
    logic [7:0]    cur_byte;

    assign full     = (count_q == CountFull);
    assign push     = load & ~full;
    assign busy     = (state_q != StIdle) | (count_q != '0);
    assign overflow = overflow_q;
    assign level    = count_q;
    assign tx       = tx_q;

    assign cur_byte = byte_sel_q ? word_q[15:8] : word_q[7:0];
    assign next_idx = bit_idx_q + 3'd1;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Memory needs no reset; the pointers and the count decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            word_q     <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
                word_q <= mem_q[rptr_q];
            end
            if (load && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // tx_d is the line level for the next cycle, so tx changes on the edge that changes state.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + CW'(1);
        bit_idx_d  = bit_idx_q;
        byte_sel_d = byte_sel_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (count_q != '0) begin
                    pop        = 1'b1;
                    byte_sel_d = 1'b0;
                    state_d    = StStart;
                    tx_d       = 1'b0;
                end
            end
            StStart: begin
                if (baud_q == BaudLast) begin
                    state_d   = StData;
                    baud_d    = '0;
                    bit_idx_d = '0;
                    tx_d      = cur_byte[0];
                end
            end
            StData: begin
                if (baud_q == BaudLast) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = next_idx;
                        tx_d      = cur_byte[next_idx];
                    end
                end
            end
            StStop: begin
                if (baud_q == BaudLast) begin
                    baud_d = '0;
                    if (!byte_sel_q) begin
                        // The high byte follows straight on, with no idle gap.
                        byte_sel_d = 1'b1;
                        state_d    = StStart;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_sel_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_sel_q <= byte_sel_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_port_tx_unit.sv
module tb_port_tx_unit;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic          clk  = 1'b0;
    logic          rst  = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   data = 16'h0;
    logic          tx;
    logic          busy;
    logic          full;
    logic          overflow;
    logic [AW:0]   level;

    int            checks = 0;
    int            errors = 0;
    int unsigned   cyc    = 0;

    // Receiver output: {stop bit, data byte} per frame, plus the cycle each frame started.
    logic [8:0]    rxq[$];
    int unsigned   starts[$];

    port_tx_unit #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH),
        .AW           (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .data     (data),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .overflow (overflow),
        .level    (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Independent UART receiver: samples each bit at mid-bit on falling clock edges.
    initial begin : rx_monitor
        logic [7:0] b;
        b = 8'h0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx === 1'b0) begin
                starts.push_back(cyc);
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                rxq.push_back({tx, b});
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        data = w;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int unsigned limit);
        int unsigned n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, {31'b0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input string tag, input logic [15:0] w);
        logic [8:0] got;
        for (int i = 0; i < 2; i++) begin
            if (rxq.size() > 0) got = rxq.pop_front();
            else got = 9'bx;
            chk(tag, {23'b0, got}, {23'b0, 1'b1, (i == 0) ? w[7:0] : w[15:8]});
        end
    endtask

    initial begin : main
        int unsigned n;
        int unsigned d1, d2;
        logic [15:0] w;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", {31'b0, tx}, 1);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_full", {31'b0, full}, 0);
        chk("rst_overflow", {31'b0, overflow}, 0);
        chk("rst_level", {29'b0, level}, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single word A55A
        push_word(16'hA55A);
        chk("t1_level_load", {29'b0, level}, 1);
        chk("t1_tx_before_pop", {31'b0, tx}, 1);
        chk("t1_busy_load", {31'b0, busy}, 1);
        @(posedge clk);
        #1;
        chk("t1_tx_start", {31'b0, tx}, 0);
        chk("t1_level_pop", {29'b0, level}, 0);
        n = 2;
        while (busy === 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            if (busy === 1'b1) n++;
        end
        chk("t1_busy_cycles", n, 81);
        repeat (2) @(posedge clk);
        #1;
        expect_word("t1_word", 16'hA55A);
        chk("t1_level_end", {29'b0, level}, 0);
        chk("t1_rx_empty", rxq.size(), 0);

        // Back-to-back words; the second load coincides with the first pop
        starts.delete();
        push_word(16'h00FF);
        push_word(16'hFF00);
        chk("t2_level_push_pop", {29'b0, level}, 1);
        wait_idle("t2_idle", 400);
        expect_word("t2_word0", 16'h00FF);
        expect_word("t2_word1", 16'hFF00);
        chk("t2_frames", starts.size(), 4);
        d1 = (starts.size() >= 3) ? starts[1] - starts[0] : 0;
        d2 = (starts.size() >= 3) ? starts[2] - starts[1] : 0;
        chk("t2_byte_gap", d1, 40);
        chk("t2_word_gap", d2, 41);

        // Overflow: six back-to-back loads
        for (int i = 1; i <= 4; i++) push_word(16'(i));
        push_word(16'h0005);
        chk("t3_full", {31'b0, full}, 1);
        chk("t3_level_full", {29'b0, level}, 4);
        chk("t3_ovf_not_yet", {31'b0, overflow}, 0);
        push_word(16'h0006);
        chk("t3_overflow", {31'b0, overflow}, 1);
        chk("t3_level_drop", {29'b0, level}, 4);
        wait_idle("t3_idle", 700);
        for (int i = 1; i <= 5; i++) expect_word("t3_word", 16'(i));
        chk("t3_rx_empty", rxq.size(), 0);
        chk("t3_ovf_sticky", {31'b0, overflow}, 1);
        rst = 1'b0;
        #2;
        chk("t3_ovf_clear", {31'b0, overflow}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset during DATA bit 3 of the first frame, two words buffered
        push_word(16'h1111);
        push_word(16'h2222);
        push_word(16'h3333);
        chk("t4_level_buf", {29'b0, level}, 2);
        repeat (16) @(posedge clk);
        #2;
        chk("t4_tx_bit3", {31'b0, tx}, 0);
        rst = 1'b0;
        #1;
        chk("t4_tx_async", {31'b0, tx}, 1);
        chk("t4_level", {29'b0, level}, 0);
        chk("t4_busy", {31'b0, busy}, 0);
        chk("t4_overflow", {31'b0, overflow}, 0);
        chk("t4_full", {31'b0, full}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (60) @(posedge clk);
        rxq.delete();
        starts.delete();
        repeat (200) @(posedge clk);
        #1;
        chk("t4_no_frames", starts.size(), 0);
        chk("t4_busy_after", {31'b0, busy}, 0);
        chk("t4_tx_after", {31'b0, tx}, 1);

        // Wrap-around: ten spaced words
        for (int i = 0; i < 10; i++) begin
            w = 16'(32'h1000 + i * 32'h0123);
            push_word(w);
            chk("t5_not_full", {31'b0, full}, 0);
            repeat (69) @(posedge clk);
            #1;
        end
        wait_idle("t5_idle", 1200);
        for (int i = 0; i < 10; i++) begin
            w = 16'(32'h1000 + i * 32'h0123);
            expect_word("t5_word", w);
        end
        chk("t5_rx_empty", rxq.size(), 0);
        chk("t5_overflow", {31'b0, overflow}, 0);
        chk("t5_level", {29'b0, level}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/port_tx_unit.md
Name: port_tx_unit

Overview:
- Downstream consumer of the CPU output port. Each time write-back loads the output register, this block captures the 16-bit word alongside it.
- Words are buffered in a small FIFO and serialised onto a single UART line as 8N1 frames, low byte first, then high byte.
- Decouples CPU OUT instructions from slow serial timing. The CPU never stalls on it; words that overflow the FIFO are dropped and flagged.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be ≥2.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- AW, 2, log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- load  in  1  write strobe; same timing as the output-register load (one cycle per OUT).
- data  in  16  word to transmit; sampled when load=1.
- tx  out  1  serial line; idle high; registered.
- busy  out  1  FIFO non-empty or transmitter not IDLE.
- full  out  1  FIFO count == DEPTH.
- overflow  out  1  sticky; set when a load is dropped.
- level  out  AW+1  current FIFO count, 0..DEPTH.

Behaviour:
- Reset (rst=0, asynchronous): tx=1, busy=0, full=0, overflow=0, level=0.
  - FIFO pointers and count cleared; FSM to IDLE; bit and byte counters cleared.
  - Reset mid-frame aborts the frame; tx is high immediately. Buffered words are discarded.
- FIFO push:
  - On a clk edge with load=1 and full=0, data is written at wptr; wptr increments modulo DEPTH.
  - If load=1 and full=1, the word is dropped and overflow is set to 1. overflow clears only on reset.
  - full uses the registered count. A load in the same cycle as a pop while full is still dropped.
- FIFO pop: occurs only in IDLE when count≠0.
  - The word at rptr is moved into a 16-bit shift holding register; rptr increments modulo DEPTH.
  - Simultaneous push and pop (not full) leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count≠0: pop, byte_sel=0, go START (tx=0 from the next edge).
  - START: tx=0 for CLKS_PER_BIT cycles, then go DATA with bit index 0.
  - DATA: tx = current byte bit[idx], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If byte_sel=0: set byte_sel=1 and go START directly to send the high byte (no idle gap).
    - If byte_sel=1: go IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. It is reset on every state entry, so bit boundaries are exact.
- Latency:
  - A load sampled at edge k with an empty FIFO and IDLE is popped at edge k+1; tx falls after edge k+1.
  - One word occupies 20*CLKS_PER_BIT cycles on the line. Back-to-back words have exactly 1 IDLE cycle (tx=1) between the high-byte stop and the next start.
- Capacity: up to DEPTH words buffered plus 1 in the shifter.
- level and full are updated on the same edge as the push/pop.
- busy is combinational from registered state: (state≠IDLE) | (count≠0).

Test Plan:
- Single word, CLKS_PER_BIT=4: load=1 with data=16'hA55A for one cycle.
  - Expected line: start 0, bits of 8'h5A LSB-first (0,1,0,1,1,0,1,0), stop 1, start 0, bits of 8'hA5 (1,0,1,0,0,1,0,1), stop 1.
  - Each bit lasts 4 cycles; tx falls one cycle after load is sampled; busy is high for 81 cycles; level returns to 0.
- Overflow: 6 back-to-back loads 16'h0001..16'h0006 while idle, DEPTH=4.
  - Expected: first word popped, next 4 buffered, full=1 after the 5th load; 6th dropped, overflow=1, level=4.
  - Line emits 0001..0005 in order.
- Back-to-back words: two loads 16'h00FF, 16'hFF00.
  - Expected: exactly one tx=1 IDLE cycle between the word-1 high-byte stop bit end and the word-2 start bit.
- Push during pop, not full: load asserted on the same edge IDLE pops with count=1.
  - Expected: level stays 1; no data lost or duplicated.
- Reset mid-frame: assert rst=0 during DATA bit 3 with 2 words buffered.
  - Expected: tx=1 asynchronously, level=0, busy=0, overflow=0; after release, no further frames.
- Wrap-around: stream 10 words with gaps so the FIFO never fills.
  - Expected: pointers wrap past DEPTH-1, all words are transmitted in order, overflow stays 0.
